// File: rtl/imem_responder_if.sv
// Instruction-fetch read bus plus loader write port between minuteCore and its instruction store.
interface imem_responder_if #(
   parameter int ADDR_SIZE  = 31,
   parameter int INSTR_SIZE = 31
);
   logic [ADDR_SIZE:0]  rd_addr;
   logic                rd_enable;
   logic [INSTR_SIZE:0] rd_data;
   logic                rd_ready;
   logic                rd_error;
   logic                wr_enable;
   logic [ADDR_SIZE:0]  wr_addr;
   logic [INSTR_SIZE:0] wr_data;

   modport master (
      output rd_addr, rd_enable, wr_enable, wr_addr, wr_data,
      input  rd_data, rd_ready, rd_error
   );

   modport slave (
      input  rd_addr, rd_enable, wr_enable, wr_addr, wr_data,
      output rd_data, rd_ready, rd_error
   );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: word array with loader write port, fixed wait states,
// one-cycle rd_ready strobe and alignment/range error flag.
module imem_responder #(
   parameter int                 DEPTH_LOG2 = 10,
   parameter int                 LATENCY    = 1,
   parameter int                 ADDR_SIZE  = 31,
   parameter int                 INSTR_SIZE = 31,
   parameter logic [ADDR_SIZE:0] BASE_ADDR  = '0
) (
   input logic              clk,
   input logic              reset,
   imem_responder_if.slave  bus
);
   localparam int AW    = ADDR_SIZE + 1;
   localparam int DW    = INSTR_SIZE + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [3:0] LAT = 4'(LATENCY);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state, state_nxt;
   logic [3:0]      wait_cnt, cnt_nxt;
   logic [AW-1:0]   addr_q, addr_nxt;
   logic [DW-1:0]   mem [DEPTH];

   logic            rdy_q, err_q;
   logic [DW-1:0]   data_q;

   logic [AW-1:0]   rd_sel, rd_off, wr_off;
   logic            rd_bad, wr_bad;

   // Base is word-aligned, so the low offset bits equal the address low bits.
   assign rd_sel = (state == WAIT) ? addr_q : bus.rd_addr;
   assign rd_off = rd_sel - BASE_ADDR;
   assign wr_off = bus.wr_addr - BASE_ADDR;
   assign rd_bad = (rd_off[1:0] != 2'b00) || (rd_sel < BASE_ADDR) ||
                   ((rd_off >> (DEPTH_LOG2 + 2)) != '0);
   assign wr_bad = (wr_off[1:0] != 2'b00) || (bus.wr_addr < BASE_ADDR) ||
                   ((wr_off >> (DEPTH_LOG2 + 2)) != '0);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = wait_cnt;
      addr_nxt  = addr_q;
      unique case (state)
         WAIT: begin
            if (!bus.rd_enable) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = wait_cnt - 4'd1;
               if (wait_cnt == 4'd1) state_nxt = RESP;
            end
         end
         default: begin
            // IDLE and RESP both accept a new request at this edge.
            state_nxt = IDLE;
            if (bus.rd_enable) begin
               addr_nxt  = bus.rd_addr;
               cnt_nxt   = LAT;
               state_nxt = (LAT == 4'd0) ? RESP : WAIT;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
         addr_q   <= '0;
         rdy_q    <= 1'b0;
         err_q    <= 1'b0;
         data_q   <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= cnt_nxt;
         addr_q   <= addr_nxt;
         if (state_nxt == RESP) begin
            rdy_q  <= 1'b1;
            err_q  <= rd_bad;
            data_q <= rd_bad ? '0 : mem[rd_off[DEPTH_LOG2+1:2]];
         end else begin
            rdy_q  <= 1'b0;
            err_q  <= 1'b0;
            data_q <= '0;
         end
      end
   end

   // Same-edge read of the written word sees the old value (read-before-write).
   always_ff @(posedge clk) begin
      if (bus.wr_enable && !wr_bad) mem[wr_off[DEPTH_LOG2+1:2]] <= bus.wr_data;
   end

   assign bus.rd_ready = rdy_q;
   assign bus.rd_error = err_q;
   assign bus.rd_data  = data_q;
endmodule
